// File: rtl/shift_sequencer_if.sv
// Request, result and external right-shifter signals for shift_sequencer.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned AW = $clog2(WIDTH) + 1;

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] operand;
  logic [AW-1:0]    amount;
  logic             mode;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             sr_enable;
  logic [WIDTH-1:0] sr_in;
  logic             sr_mode;
  logic [WIDTH-1:0] sr_out;

  modport master (
    output start_valid, operand, amount, mode, result_ready,
    input  start_ready, result_valid, result, busy
  );

  modport shifter (
    input  sr_enable, sr_in, sr_mode,
    output sr_out
  );

  modport slave (
    input  start_valid, operand, amount, mode, result_ready, sr_out,
    output start_ready, result_valid, result, busy, sr_enable, sr_in, sr_mode
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift built by iterating an external registered 1-bit right shifter.
module shift_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);
  localparam int unsigned AW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [AW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] op_q, op_n;
  logic [WIDTH-1:0] res_q, res_n;
  logic             mode_q, mode_n;
  logic             first_q, first_n;
  logic [AW-1:0]    amt_sat;

  logic             start_ready_c;
  logic             result_valid_c;
  logic             busy_c;
  logic             sr_enable_c;
  logic [WIDTH-1:0] sr_in_c;

  // Distances beyond WIDTH produce the same result as exactly WIDTH steps.
  assign amt_sat = (bus.amount > AW'(WIDTH)) ? AW'(WIDTH) : bus.amount;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_q    <= op_n;
      res_q   <= res_n;
      mode_q  <= mode_n;
      first_q <= first_n;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    op_n           = op_q;
    res_n          = res_q;
    mode_n         = mode_q;
    first_n        = first_q;
    start_ready_c  = 1'b0;
    result_valid_c = 1'b0;
    busy_c         = 1'b1;
    sr_enable_c    = 1'b0;
    sr_in_c        = '0;

    case (state)
      IDLE: begin
        start_ready_c = 1'b1;
        busy_c        = 1'b0;
        if (bus.start_valid) begin
          op_n   = bus.operand;
          mode_n = bus.mode;
          cnt_n  = amt_sat;
          if (amt_sat == '0) begin
            res_n   = bus.operand;
            state_n = DONE;
          end else begin
            first_n = 1'b1;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        // First step seeds the shifter from the operand, later steps recirculate.
        sr_enable_c = 1'b1;
        sr_in_c     = first_q ? op_q : bus.sr_out;
        first_n     = 1'b0;
        cnt_n       = cnt - AW'(1);
        if (cnt == AW'(1)) begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        res_n   = bus.sr_out;
        state_n = DONE;
      end
      DONE: begin
        result_valid_c = 1'b1;
        if (bus.result_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.start_ready  = start_ready_c;
  assign bus.result_valid = result_valid_c;
  assign bus.busy         = busy_c;
  assign bus.sr_enable    = sr_enable_c;
  assign bus.sr_in        = sr_in_c;
  assign bus.sr_mode      = mode_q;
  assign bus.result       = res_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed and random shifts against an arithmetic reference.
module tb_shift_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = $clog2(W) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sr_q = '0;
  int           checks = 0;
  int           errors = 0;
  string        cur_tag = "init";

  shift_sequencer_if #(.WIDTH(W)) bus ();

  shift_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External registered 1-bit right shifter.
  always @(posedge clk) begin
    if (bus.sr_enable)
      sr_q <= bus.sr_mode ? {1'b0, bus.sr_in[W-1:1]} : {bus.sr_in[W-1], bus.sr_in[W-1:1]};
  end
  assign bus.sr_out = sr_q;

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int amt, input bit m);
    int n;
    logic signed [W-1:0] s;
    n = (amt > int'(W)) ? int'(W) : amt;
    s = v;
    if (m) return v >> n;
    return s >>> n;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", cur_tag, name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic [W-1:0] res_exp, input bit chk_res);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("result_valid_idle", 32'(bus.result_valid), 32'd0);
    chk("sr_enable_idle", 32'(bus.sr_enable), 32'd0);
    chk("start_ready_idle", 32'(bus.start_ready), 32'd1);
    if (chk_res) chk("result_reset", 32'(bus.result), 32'(res_exp));
  endtask

  // One full request: accept, track per-cycle latency, hold in DONE, consume.
  task automatic run_op(input string tag, input logic [W-1:0] opv, input int amt, input bit m,
                        input int hold, input logic [W-1:0] exp);
    int n;
    int v;
    cur_tag = tag;
    n = (amt > int'(W)) ? int'(W) : amt;
    v = (n == 0) ? 1 : n + 2;
    chk("start_ready_pre", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.operand     = opv;
    bus.amount      = AW'(amt);
    bus.mode        = m;
    step();
    for (int c = 1; c <= v; c++) begin
      bus.start_valid = 1'($urandom);
      bus.operand     = W'($urandom);
      bus.amount      = AW'($urandom);
      bus.mode        = 1'($urandom);
      chk("sr_enable", 32'(bus.sr_enable), 32'(c <= n));
      chk("result_valid", 32'(bus.result_valid), 32'(c == v));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("start_ready_busy", 32'(bus.start_ready), 32'd0);
      chk("sr_mode", 32'(bus.sr_mode), 32'(m));
      if (c > n) chk("sr_in_idle", 32'(bus.sr_in), 32'd0);
      if (c < v) step();
    end
    chk("result", 32'(bus.result), 32'(exp));
    bus.start_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus.operand = W'($urandom);
      step();
      chk("result_hold", 32'(bus.result), 32'(exp));
      chk("result_valid_hold", 32'(bus.result_valid), 32'd1);
      chk("start_ready_hold", 32'(bus.start_ready), 32'd0);
    end
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    bus.start_valid  = 1'b0;
    check_idle('0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ro;
    int           ra;
    bit           rm;

    rst              = 1'b1;
    bus.start_valid  = 1'b0;
    bus.operand      = '0;
    bus.amount       = '0;
    bus.mode         = 1'b0;
    bus.result_ready = 1'b0;
    step();
    step();
    cur_tag = "reset";
    check_idle('0, 1'b1);
    rst = 1'b0;
    step();

    run_op("asr4",      16'hF000, 4,  1'b0, 0, 16'hFF00);
    run_op("lsr4",      16'hF000, 4,  1'b1, 0, 16'h0F00);
    run_op("zero_amt",  16'h1234, 0,  1'b0, 0, 16'h1234);
    run_op("sat_asr",   16'h8001, 20, 1'b0, 0, 16'hFFFF);
    run_op("sat_lsr",   16'h8001, 20, 1'b1, 0, 16'h0000);
    run_op("hold5",     16'h00F0, 2,  1'b1, 5, 16'h003C);
    run_op("full_asr",  16'h8001, 16, 1'b0, 1, 16'hFFFF);
    run_op("one_asr",   16'h8000, 1,  1'b0, 0, 16'hC000);
    run_op("max_amt",   16'h7FFF, 31, 1'b0, 2, 16'h0000);

    // Reset during the second SHIFT cycle aborts the operation.
    cur_tag          = "reset_mid";
    bus.start_valid  = 1'b1;
    bus.operand      = 16'hABCD;
    bus.amount       = AW'(8);
    bus.mode         = 1'b0;
    step();
    bus.start_valid  = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle('0, 1'b1);
    step();
    chk("no_result_after_abort", 32'(bus.result_valid), 32'd0);
    run_op("after_reset", 16'hABCD, 8, 1'b0, 1, 16'hFFAB);

    // Reset while a result waits in DONE.
    cur_tag          = "reset_done";
    bus.start_valid  = 1'b1;
    bus.operand      = 16'h5A5A;
    bus.amount       = '0;
    step();
    bus.start_valid  = 1'b0;
    chk("done_valid", 32'(bus.result_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle('0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = W'($urandom);
      ra = int'($urandom_range(0, 31));
      rm = 1'($urandom);
      run_op($sformatf("rand%0d", i), ro, ra, rm, int'($urandom_range(0, 3)), ref_shift(ro, ra, rm));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; WIDTH SHALL be >= 2.
REQ-002 Derived constant AW = $clog2(WIDTH)+1: shift-amount width (5 when WIDTH=16).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_valid  input  1  request to begin an operation.
REQ-006 start_ready  output  1  sequencer can accept a request.
REQ-007 operand  input  WIDTH  value to shift, sampled at acceptance.
REQ-008 amount  input  AW  shift distance in bits, sampled at acceptance.
REQ-009 mode  input  1  shift type, sampled at acceptance: 0 = arithmetic, 1 = logical.
REQ-010 result_valid  output  1  result is available.
REQ-011 result_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  shifted value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 sr_enable  output  1  enable to the external 1-bit right shifter.
REQ-015 sr_in  output  WIDTH  data input to the external shifter.
REQ-016 sr_mode  output  1  mode input to the external shifter.
REQ-017 sr_out  input  WIDTH  registered output fed back from the external shifter.

Function
REQ-018 The external shifter contract SHALL be: if sr_enable=1 at an edge, sr_out after that edge equals sr_in shifted right by 1. With sr_mode=0 the MSB is copied from sr_in[WIDTH-1]. With sr_mode=1 the MSB is 0. With sr_enable=0, sr_out holds.
REQ-019 FSM states SHALL be IDLE, SHIFT, CAPTURE and DONE.
REQ-020 start_ready SHALL equal 1 only in IDLE; a request is accepted at an edge where start_valid=1 and start_ready=1.
REQ-021 At acceptance, the block SHALL latch operand, mode and cnt = min(amount, WIDTH).
REQ-022 Accept with cnt=0: go to DONE, with result = operand; sr_enable never asserts for this request.
REQ-023 Accept with cnt>=1: go to SHIFT.
REQ-024 SHIFT: sr_enable=1 on every cycle.
REQ-025 SHIFT data source: sr_in = latched operand on the first SHIFT cycle, and sr_out on later SHIFT cycles.
REQ-026 SHIFT counting: cnt decrements each cycle; when cnt=1, the next state is CAPTURE.
REQ-027 SHIFT SHALL last exactly cnt cycles.
REQ-028 CAPTURE SHALL last one cycle, with result <= sr_out, sr_enable=0, then go to DONE.
REQ-029 DONE: result_valid=1 and result stable until the edge where result_ready=1; then go to IDLE.
REQ-030 result_valid SHALL be 0 in all states except DONE.
REQ-031 Latency, with acceptance edge = cycle 0: cnt=0 gives result_valid high in cycle 1; cnt=N>=1 gives SHIFT in cycles 1..N, CAPTURE in cycle N+1 and result_valid in cycle N+2.
REQ-032 start_valid SHALL be ignored outside IDLE.
REQ-033 Changes on operand, amount and mode after acceptance SHALL have no effect on the operation in progress.
REQ-034 sr_mode SHALL equal the latched mode at all times.
REQ-035 sr_in SHALL be 0 whenever sr_enable=0.
REQ-036 amount >= WIDTH SHALL saturate to WIDTH shifts: result is all zeros (logical) or all copies of the operand MSB (arithmetic).
REQ-037 A new request SHALL NOT be accepted on the same edge that the result is consumed; the earliest next acceptance is one cycle after the DONE->IDLE transition.

Reset
REQ-038 When rst=1 at an edge, state SHALL become IDLE, cnt=0, result=0 and the latched operand and mode SHALL become 0.
REQ-039 Following a reset edge, outputs SHALL be result_valid=0, busy=0, sr_enable=0 and start_ready=1.
REQ-040 rst SHALL take priority over every other input, including mid-SHIFT and in DONE; the in-progress operation is aborted and produces no result.

Verification
REQ-041 operand=0xF000, amount=4, mode=0 -> sr_enable high exactly in cycles 1-4, result_valid in cycle 6, result=0xFF00.
REQ-042 operand=0xF000, amount=4, mode=1 -> result=0x0F00 in cycle 6.
REQ-043 operand=0x1234, amount=0 -> result_valid in cycle 1, result=0x1234, sr_enable never high.
REQ-044 operand=0x8001, amount=20, mode=0 -> 16 enable cycles, result=0xFFFF; same request with mode=1 -> result=0x0000.
REQ-045 result_ready held low for 5 cycles in DONE while start_valid=1 with new operand -> result stable, start_ready=0, no new acceptance; result_ready=1 -> IDLE next cycle.
REQ-046 rst=1 in cycle 2 of an amount=8 shift -> next cycle IDLE, busy=0, result_valid=0, sr_enable=0; a following request completes correctly.
